// File: rtl/uart_pkg.sv
// Shared UART definitions: data-bit encodings, RX state encoding, oversampling constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;

    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP0,
        STOP1,
        WAIT_IDLE
    } rx_state_t;

    // Index of the final data bit for a given data-bits code (5 bits -> 4 ... 8 bits -> 7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return 3'd4 + {1'b0, data_bits};
    endfunction

endpackage

// File: rtl/sync_fifo_with_clear.sv
// Generic synchronous FIFO with a flush input; optional registered head output.
// Latency: write visible at the head on the next cycle (registered or not).
// Backpressure: writes dropped when full unless a pop happens the same cycle; pops on empty ignored.
module sync_fifo_with_clear #(
    parameter int DATA_WIDTH            = 8,
    parameter int DEPTH                 = 16,
    parameter int EXTRA_OUTPUT_REGISTER = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_ptr_n;
    logic [AW:0]           count;
    logic                  wr_do;
    logic                  rd_do;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_do    = rd_en && !empty;
    assign wr_do    = wr_en && (!full || rd_do);
    assign rd_ptr_n = rd_do ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_do) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_n;
            count  <= count + (AW+1)'(wr_do) - (AW+1)'(rd_do);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    generate
        if (EXTRA_OUTPUT_REGISTER != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] head_q;
            // Preload the head that will exist after this cycle; bypass when writing into an empty slot.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    head_q <= '0;
                end else if (!clear) begin
                    head_q <= (wr_do && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
                end
            end
            assign rd_data = head_q;
        end else begin : g_out_comb
            assign rd_data = mem[rd_ptr];
        end
    endgenerate

endmodule

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous serial line; resets to the idle (high) level.
// Latency: STAGES cycles.
// Backpressure: none.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (5-8 data bits, optional even parity, 1/2 stop) feeding an RX FIFO.
// Latency: byte at FIFO head 2 cycles after the final stop-bit sample.
// Backpressure: none on the line; characters arriving while the FIFO is full are dropped and flagged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_parity,
    input  logic [1:0] i_data_bits,
    input  logic       i_stop_bits,
    input  logic       i_fifo_rd_en,
    input  logic       i_fifo_clear,
    output logic [7:0] o_fifo_rd_data,
    output logic       o_fifo_empty,
    output logic       o_fifo_full,
    input  logic       i_err_clear,
    output logic       o_overflow_error,
    output logic       o_parity_error,
    output logic       o_frame_error,
    input  logic       i_rx_strb16,
    output logic       o_rx_strb_en,
    input  logic       i_uart_rx
);

    logic       rxs;
    logic       rxs_q;

    rx_state_t  state, state_n;
    logic [3:0] tick_cnt, tick_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift_q, shift_n;
    logic       calc_par, par_n;
    logic       perr, perr_n;
    logic       fin_pend, fin_n;
    logic       cfg_par, cfg_par_n;
    logic [1:0] cfg_bits, cfg_bits_n;
    logic       cfg_stop, cfg_stop_n;
    logic       perr_set;
    logic       ferr_set;
    logic       ovf_set;
    logic       push;
    logic       hit_mid;
    logic       hit_end;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_uart_rx),
        .q     (rxs)
    );

    assign hit_mid = i_rx_strb16 && (tick_cnt == 4'(MID_TICK - 1));
    assign hit_end = i_rx_strb16 && (tick_cnt == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            calc_par <= 1'b0;
            perr     <= 1'b0;
            fin_pend <= 1'b0;
            cfg_par  <= 1'b0;
            cfg_bits <= DATA_BITS_8;
            cfg_stop <= 1'b0;
            rxs_q    <= 1'b1;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shift_q  <= shift_n;
            calc_par <= par_n;
            perr     <= perr_n;
            fin_pend <= fin_n;
            cfg_par  <= cfg_par_n;
            cfg_bits <= cfg_bits_n;
            cfg_stop <= cfg_stop_n;
            rxs_q    <= rxs;
        end
    end

    always_comb begin
        state_n      = state;
        tick_n       = i_rx_strb16 ? tick_cnt + 4'd1 : tick_cnt;
        bit_n        = bit_cnt;
        shift_n      = shift_q;
        par_n        = calc_par;
        perr_n       = perr;
        fin_n        = 1'b0;
        cfg_par_n    = cfg_par;
        cfg_bits_n   = cfg_bits;
        cfg_stop_n   = cfg_stop;
        perr_set     = 1'b0;
        ferr_set     = 1'b0;
        o_rx_strb_en = 1'b0;

        unique case (state)
            IDLE: begin
                if (rxs_q && !rxs) begin
                    tick_n     = '0;
                    bit_n      = '0;
                    shift_n    = '0;
                    par_n      = 1'b0;
                    perr_n     = 1'b0;
                    cfg_par_n  = i_parity;
                    cfg_bits_n = i_data_bits;
                    cfg_stop_n = i_stop_bits;
                    state_n    = START;
                end
            end
            START: begin
                o_rx_strb_en = 1'b1;
                if (hit_mid) begin
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        tick_n  = '0;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                o_rx_strb_en = 1'b1;
                if (hit_end) begin
                    shift_n[bit_cnt] = rxs;
                    par_n            = calc_par ^ rxs;
                    if (bit_cnt == last_bit_idx(cfg_bits)) begin
                        state_n = cfg_par ? PARITY : STOP0;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                o_rx_strb_en = 1'b1;
                if (hit_end) begin
                    perr_n   = (rxs != calc_par);
                    perr_set = perr_n;
                    state_n  = STOP0;
                end
            end
            STOP0: begin
                o_rx_strb_en = 1'b1;
                if (hit_end) begin
                    if (!rxs) begin
                        ferr_set = 1'b1;
                        state_n  = WAIT_IDLE;
                    end else if (cfg_stop) begin
                        state_n = STOP1;
                    end else begin
                        fin_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            STOP1: begin
                o_rx_strb_en = 1'b1;
                if (hit_end) begin
                    if (!rxs) begin
                        ferr_set = 1'b1;
                        state_n  = WAIT_IDLE;
                    end else begin
                        fin_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Parity failures never reach the FIFO; framing failures never reach finish at all.
    assign push    = fin_pend && !perr;
    assign ovf_set = push && o_fifo_full && !i_fifo_rd_en && !i_fifo_clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_overflow_error <= 1'b0;
            o_parity_error   <= 1'b0;
            o_frame_error    <= 1'b0;
        end else begin
            o_overflow_error <= (o_overflow_error && !i_err_clear) || ovf_set;
            o_parity_error   <= (o_parity_error && !i_err_clear) || perr_set;
            o_frame_error    <= (o_frame_error && !i_err_clear) || ferr_set;
        end
    end

    sync_fifo_with_clear #(
        .DATA_WIDTH            (8),
        .DEPTH                 (FIFO_DEPTH),
        .EXTRA_OUTPUT_REGISTER (1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (i_fifo_clear),
        .wr_en   (push),
        .wr_data (shift_q),
        .rd_en   (i_fifo_rd_en),
        .rd_data (o_fifo_rd_data),
        .empty   (o_fifo_empty),
        .full    (o_fifo_full)
    );

endmodule
